// File: rtl/dsp_uart_pkg.sv
// Shared definitions for the display UART output stage: TX FSM states and
// word/byte geometry.
package dsp_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned WORD_W         = UART_BITS * BYTES_PER_WORD;

endpackage

// File: rtl/dsp_uart_fifo.sv
// Show-ahead synchronous FIFO buffering captured display words.
// dout always presents the head entry; it is valid while empty is low.
module dsp_fifo
  import dsp_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/dsp_uart.sv
// Display output stage: captures OUT words from the CPU bus into a FIFO and
// sends each as two 8N1 UART bytes, high byte first.
module dsp_uart
  import dsp_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        dsp_in_en,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(UART_BITS);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [IW-1:0]  bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     lo_q, lo_d;
  logic           byte_sel_q, byte_sel_d;
  logic           overflow_q, overflow_d;
  logic           pop;
  logic           tick;
  logic [15:0]    fifo_dout;

  dsp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (dsp_in_en),
    .pop  (pop),
    .din  (in),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  assign tick = (baud_q == BW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      lo_q       <= '0;
      byte_sel_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      lo_q       <= lo_d;
      byte_sel_q <= byte_sel_d;
      overflow_q <= overflow_d;
    end
  end

  // The low byte is latched at pop time because the FIFO head moves on.
  always_comb begin
    state_d    = state_q;
    baud_d     = tick ? '0 : baud_q + BW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    lo_d       = lo_q;
    byte_sel_d = byte_sel_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (dsp_in_en & full);
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout[15:8];
          lo_d       = fifo_dout[7:0];
          byte_sel_d = 1'b0;
          bit_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == IW'(UART_BITS - 1)) state_d = STOP;
          else                            bit_d   = bit_q + IW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (!byte_sel_q) begin
            shift_d    = lo_q;
            byte_sel_d = 1'b1;
            state_d    = START;
          end else if (!empty) begin
            pop        = 1'b1;
            shift_d    = fifo_dout[15:8];
            lo_d       = fifo_dout[7:0];
            byte_sel_d = 1'b0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
    busy = (state_q != IDLE) | ~empty;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_dsp_uart.sv
// Directed bench for dsp_uart with CLK_DIV=4, DEPTH=4: per-word vector table
// plus hand-written overflow, push+pop, back-to-back and mid-frame reset cases.
module tb_dsp_uart;

  localparam int unsigned CDIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        dsp_in_en;
  logic        tx, busy, full, empty, overflow;

  int errors = 0;
  int checks = 0;

  dsp_uart #(
    .CLK_DIV(CDIV),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .dsp_in_en(dsp_in_en),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Samples one frame whose start bit appears at the next falling edge.
  task automatic rx_frame(output logic [7:0] b, output logic ok);
    logic first;
    ok = 1'b1;
    b  = '0;
    repeat (CDIV) begin
      @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      first = tx;
      b[i]  = tx;
      repeat (CDIV - 1) begin
        @(negedge clk);
        if (tx !== first) ok = 1'b0;
      end
    end
    repeat (CDIV) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic rx_check(input string nm, input logic [7:0] exp);
    logic [7:0] b;
    logic       ok;
    rx_frame(b, ok);
    chk($sformatf("%s byte", nm), {8'h00, b}, {8'h00, exp});
    chk($sformatf("%s framing", nm), {15'd0, ok}, 16'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{word: 16'hA55A, hi: 8'hA5, lo: 8'h5A};
    vecs[1] = '{word: 16'h0000, hi: 8'h00, lo: 8'h00};
    vecs[2] = '{word: 16'hFFFF, hi: 8'hFF, lo: 8'hFF};
    vecs[3] = '{word: 16'h1234, hi: 8'h12, lo: 8'h34};
    vecs[4] = '{word: 16'h80C1, hi: 8'h80, lo: 8'hC1};

    rst = 1'b0; dsp_in_en = 1'b0; in = '0;
    repeat (3) @(negedge clk);
    chk("reset tx", {15'd0, tx}, 16'd1);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset empty", {15'd0, empty}, 16'd1);
    chk("reset full", {15'd0, full}, 16'd0);
    chk("reset overflow", {15'd0, overflow}, 16'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single words: tx low one edge after capture, busy drops 80 cycles later.
    for (int v = 0; v < 5; v++) begin
      in = vecs[v].word; dsp_in_en = 1'b1;
      @(negedge clk);
      dsp_in_en = 1'b0;
      chk($sformatf("v%0d tx before start", v), {15'd0, tx}, 16'd1);
      chk($sformatf("v%0d busy queued", v), {15'd0, busy}, 16'd1);
      chk($sformatf("v%0d empty queued", v), {15'd0, empty}, 16'd0);
      rx_check($sformatf("v%0d hi", v), vecs[v].hi);
      rx_check($sformatf("v%0d lo", v), vecs[v].lo);
      chk($sformatf("v%0d busy last stop", v), {15'd0, busy}, 16'd1);
      @(negedge clk);
      chk($sformatf("v%0d busy end", v), {15'd0, busy}, 16'd0);
      chk($sformatf("v%0d tx idle", v), {15'd0, tx}, 16'd1);
      chk($sformatf("v%0d empty end", v), {15'd0, empty}, 16'd1);
      repeat (3) @(negedge clk);
    end

    // Extremes back-to-back: 0000 then FFFF.
    in = 16'h0000; dsp_in_en = 1'b1;
    fork
      begin
        @(negedge clk); in = 16'hFFFF;
        @(negedge clk); dsp_in_en = 1'b0;
      end
      begin
        @(negedge clk);
        rx_check("ext b0", 8'h00);
        rx_check("ext b1", 8'h00);
        rx_check("ext b2", 8'hFF);
        rx_check("ext b3", 8'hFF);
      end
    join
    @(negedge clk);
    chk("ext busy end", {15'd0, busy}, 16'd0);
    repeat (3) @(negedge clk);

    // Push and pop on the same edge at the end of the low-byte stop bit.
    in = 16'h3C3C; dsp_in_en = 1'b1;
    fork
      begin
        @(negedge clk); in = 16'h4B4B;
        @(negedge clk); dsp_in_en = 1'b0;
        repeat (79) @(negedge clk);
        in = 16'h6996; dsp_in_en = 1'b1;
        @(negedge clk); dsp_in_en = 1'b0;
        chk("pp empty", {15'd0, empty}, 16'd0);
        chk("pp full", {15'd0, full}, 16'd0);
        chk("pp overflow", {15'd0, overflow}, 16'd0);
      end
      begin
        @(negedge clk);
        rx_check("pp w1 hi", 8'h3C);
        rx_check("pp w1 lo", 8'h3C);
        rx_check("pp w2 hi", 8'h4B);
        rx_check("pp w2 lo", 8'h4B);
        rx_check("pp w3 hi", 8'h69);
        rx_check("pp w3 lo", 8'h96);
      end
    join
    @(negedge clk);
    chk("pp busy end", {15'd0, busy}, 16'd0);
    chk("pp empty end", {15'd0, empty}, 16'd1);
    repeat (3) @(negedge clk);

    // Overflow: six writes while idle, the sixth dropped.
    in = 16'h0001; dsp_in_en = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          @(negedge clk);
          if (i == 1) begin
            chk("ov empty after w1", {15'd0, empty}, 16'd0);
            chk("ov tx after w1", {15'd0, tx}, 16'd1);
          end
          if (i == 4) chk("ov full after w4", {15'd0, full}, 16'd0);
          if (i == 5) begin
            chk("ov full after w5", {15'd0, full}, 16'd1);
            chk("ov overflow after w5", {15'd0, overflow}, 16'd0);
          end
          in = 16'(i + 1);
        end
        @(negedge clk);
        dsp_in_en = 1'b0;
        chk("ov overflow after w6", {15'd0, overflow}, 16'd1);
        chk("ov full after w6", {15'd0, full}, 16'd1);
      end
      begin
        @(negedge clk);
        for (int w = 1; w <= 5; w++) begin
          rx_check($sformatf("ov w%0d hi", w), 8'h00);
          rx_check($sformatf("ov w%0d lo", w), 8'(w));
        end
      end
    join
    @(negedge clk);
    chk("ov busy end", {15'd0, busy}, 16'd0);
    chk("ov empty end", {15'd0, empty}, 16'd1);
    chk("ov overflow sticky", {15'd0, overflow}, 16'd1);
    repeat (3) @(negedge clk);

    // Mid-frame reset during data bit 3 of the first byte, two words queued.
    in = 16'hF7F7; dsp_in_en = 1'b1;
    @(negedge clk); in = 16'h1111;
    @(negedge clk); in = 16'h2222;
    @(negedge clk); dsp_in_en = 1'b0;
    repeat (16) @(negedge clk);
    chk("mr tx in bit3", {15'd0, tx}, 16'd0);
    chk("mr empty before", {15'd0, empty}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr tx", {15'd0, tx}, 16'd1);
    chk("mr empty", {15'd0, empty}, 16'd1);
    chk("mr busy", {15'd0, busy}, 16'd0);
    chk("mr full", {15'd0, full}, 16'd0);
    chk("mr overflow", {15'd0, overflow}, 16'd0);
    rst = 1'b1;
    begin
      logic quiet;
      quiet = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("mr line quiet", {15'd0, quiet}, 16'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_uart.md
Name: dsp_uart

Overview:
- Display output stage directly downstream of the controller.
- Captures the 16-bit data bus whenever the controller raises dsp_in_en, which happens during an OUT instruction (direct or indirect).
- Buffers captured words in a small FIFO and serialises each one as two 8N1 UART bytes on a single tx line, so OUT never stalls the CPU.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit; legal range 2..65535.
- DEPTH, 8: FIFO depth in 16-bit words; power of two, range 2..64.
- AW, $clog2(DEPTH): FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- in  input  16  CPU data bus.
- dsp_in_en  input  1  capture strobe from the controller; the bus is valid while it is high.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- overflow  output  1  sticky; set when a capture is dropped.

Behaviour:
- Reset (rst==0 at posedge):
  - tx=1, busy=0, full=0, empty=1, overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0; bit index = 0; byte_sel = 0.
  - Reset wins over every other event in the same cycle, including a mid-frame reset: the line returns high at that edge and the interrupted word is discarded.
- Capture:
  - At a posedge with dsp_in_en==1 and full==0, write `in` to the FIFO.
  - With full==1 the word is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
  - dsp_in_en high for N cycles writes N words.
- FIFO:
  - Registered count with simultaneous push and pop allowed; count is unchanged on push+pop.
  - full = (count==DEPTH); empty = (count==0); both are registered-state derived, with no combinational path from dsp_in_en.
  - Pointers wrap modulo DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head word. Load shift register with word[15:8], set byte_sel=0, go to START, and drive tx=0 from that edge. A word written at edge k therefore puts tx low at edge k+1.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLK_DIV cycles per bit, LSB first; shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end:
    - if byte_sel==0: load word[7:0], set byte_sel=1, go to START;
    - else if !empty: pop the next word and go to START, giving back-to-back frames with no idle gap;
    - else: go to IDLE.
- Timing:
  - Baud counter counts from 0 to CLK_DIV-1 and resets on every state/bit change.
  - One word = 20*CLK_DIV cycles on the line.
- busy = (state!=IDLE) | !empty.
- Width rules: count is AW+1 bits. The baud counter is wide enough to hold CLK_DIV-1.
- Byte order: high byte first, then low byte.

Decomposition:
- Shared package/include (dsp_defs.v):
  - FSM state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - UART_BITS=8;
  - BYTES_PER_WORD=2.
- One sub-module, dsp_fifo: synchronous FIFO with parameters DEPTH/width 16 and ports clk, rst, push, pop, din, dout, full, empty.
  - dout is the head entry, valid while !empty (show-ahead).
  - dsp_fifo also uses the same active-low synchronous reset.
- dsp_uart contains the FSM, baud counter, shift register and overflow flag.

Test Plan (CLK_DIV=4, DEPTH=4):
- Reset: hold rst=0 for 3 cycles -> tx=1, busy=0, empty=1, full=0, overflow=0.
- Single word: one-cycle dsp_in_en with in=16'hA55A at edge k -> expected response:
  - tx=0 from edge k+1;
  - data bits 1,0,1,0,0,1,0,1 (0xA5), then stop;
  - start bit, then 0,1,0,1,1,0,1,0 (0x5A), then stop;
  - each level lasts 4 cycles;
  - busy falls 80 cycles after edge k+1.
- Overflow: 6 consecutive dsp_in_en cycles with words 16'h0001..16'h0006 while idle -> expected response:
  - word 1 popped at the second edge; full=1 after the fifth write;
  - the sixth word is dropped and overflow=1;
  - exactly 5 words (10 bytes: 00 01 00 02 … 00 05) appear back-to-back with no idle gap.
- Push+pop same cycle: FIFO holding 1 word at the end of STOP (byte_sel=1), with dsp_in_en high at that edge -> expected response:
  - the head is popped and the new word written;
  - count stays 1; no drop; overflow stays 0.
- Mid-frame reset: rst=0 during DATA bit 3 of the first byte, with 2 words queued -> expected response:
  - at the next edge tx=1, empty=1, busy=0;
  - after rst=1, tx stays high with no residual frame.
- Extreme values: words 16'h0000 then 16'hFFFF -> expected response:
  - bytes 00,00,FF,FF;
  - stop bits are high even after all-zero data;
  - start bits are low even after all-one data.
